cache_mem_ctrl: RTL

//  Parametrised direct-mapped cache controller with a multi-beat refill FSM.

---
 rtl/cache_mem_ctrl_if.sv | 40 ++++
 rtl/cache_mem_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cache_mem_ctrl_if.sv
// Bundle between the cache controller, the load/store port and backing memory.
// The slave view is the controller itself; master is the environment driving it.
interface cache_mem_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) ();
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  flush;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ready;
    logic                  hit;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;
    logic [CNT_WIDTH-1:0]  hit_count;
    logic [CNT_WIDTH-1:0]  miss_count;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush,
        input  mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, hit,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output hit_count, miss_count
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush,
        output mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, hit,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache controller
// with a word-serial multi-beat refill and saturating hit/miss counters.
module cache_mem_ctrl #(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int CNT_WIDTH      = 16
) (
    input logic clk,
    input logic reset,
    cache_mem_ctrl_if.slave bus
);
    localparam int OB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(NUM_LINES);
    localparam int WB = ADDR_WIDTH - 2;
    localparam int TB = WB - OB - IB;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, WRITE} stateT;
    stateT state, nextState;

    logic                  reqWe;
    logic [WB-1:0]         reqWord;
    logic [DATA_WIDTH-1:0] reqWdata;
    logic [OB-1:0]         beat;
    logic [NUM_LINES-1:0]  valid;
    logic [TB-1:0]         tagRam [NUM_LINES];
    logic [DATA_WIDTH-1:0] dataRam [NUM_LINES][WORDS_PER_LINE];

    logic [DATA_WIDTH-1:0] rdataQ;
    logic                  readyQ;
    logic                  hitQ;
    logic [CNT_WIDTH-1:0]  hitCnt;
    logic [CNT_WIDTH-1:0]  missCnt;

    logic                  memReq;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWdata;

    logic [TB-1:0] tag;
    logic [IB-1:0] idx;
    logic [OB-1:0] off;
    logic          lookupHit;
    logic          lastBeat;
    logic          refillAck;
    logic [1:0]    unusedAddrLsb;

    assign tag       = reqWord[WB-1:OB+IB];
    assign idx       = reqWord[OB+IB-1:OB];
    assign off       = reqWord[OB-1:0];
    assign lookupHit = valid[idx] && (tagRam[idx] == tag);
    assign lastBeat  = &beat;
    assign refillAck = (state == REFILL) && bus.mem_ack;
    assign unusedAddrLsb = bus.cpu_addr[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Memory outputs are decoded from state so reset drops mem_req at once.
    always_comb begin
        nextState = state;
        memReq    = 1'b0;
        memWe     = 1'b0;
        memAddr   = '0;
        memWdata  = '0;
        unique case (state)
            IDLE: begin
                if (!bus.flush && bus.cpu_req) nextState = LOOKUP;
            end
            LOOKUP: begin
                if (reqWe)          nextState = WRITE;
                else if (lookupHit) nextState = IDLE;
                else                nextState = REFILL;
            end
            REFILL: begin
                memReq  = 1'b1;
                memAddr = {reqWord[WB-1:OB], beat, 2'b00};
                if (bus.mem_ack && lastBeat) nextState = IDLE;
            end
            WRITE: begin
                memReq   = 1'b1;
                memWe    = 1'b1;
                memAddr  = {reqWord, 2'b00};
                memWdata = reqWdata;
                if (bus.mem_ack) nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid    <= '0;
            reqWe    <= 1'b0;
            reqWord  <= '0;
            reqWdata <= '0;
            beat     <= '0;
            rdataQ   <= '0;
            readyQ   <= 1'b0;
            hitQ     <= 1'b0;
            hitCnt   <= '0;
            missCnt  <= '0;
        end else begin
            readyQ <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.flush) begin
                        valid <= '0;
                    end else if (bus.cpu_req) begin
                        reqWe    <= bus.cpu_we;
                        reqWord  <= bus.cpu_addr[ADDR_WIDTH-1:2];
                        reqWdata <= bus.cpu_wdata;
                    end
                end
                LOOKUP: begin
                    hitQ <= lookupHit;
                    beat <= '0;
                    if (lookupHit) begin
                        if (~&hitCnt) hitCnt <= hitCnt + CNT_WIDTH'(1);
                    end else begin
                        if (~&missCnt) missCnt <= missCnt + CNT_WIDTH'(1);
                    end
                    if (!reqWe && lookupHit) begin
                        rdataQ <= dataRam[idx][off];
                        readyQ <= 1'b1;
                    end
                end
                REFILL: begin
                    if (bus.mem_ack) begin
                        beat <= beat + OB'(1);
                        if (lastBeat) begin
                            valid[idx] <= 1'b1;
                            rdataQ <= (off == beat) ? bus.mem_rdata
                                                    : dataRam[idx][off];
                            readyQ <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) readyQ <= 1'b1;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; only the valid bits gate them.
    always_ff @(posedge clk) begin
        if (state == LOOKUP && reqWe && lookupHit)
            dataRam[idx][off] <= reqWdata;
        if (refillAck) begin
            dataRam[idx][beat] <= bus.mem_rdata;
            if (lastBeat) tagRam[idx] <= tag;
        end
    end

    assign bus.cpu_rdata  = rdataQ;
    assign bus.cpu_ready  = readyQ;
    assign bus.hit        = hitQ;
    assign bus.mem_req    = memReq;
    assign bus.mem_we     = memWe;
    assign bus.mem_addr   = memAddr;
    assign bus.mem_wdata  = memWdata;
    assign bus.hit_count  = hitCnt;
    assign bus.miss_count = missCnt;
endmodule
